midi_uart_tx: RTL
=================

Name: midi_uart_tx

Overview:
- Serial MIDI transmitter: accepts bytes over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each byte onto one MIDI output line as 8N1 UART at 31250 baud, derived from the system clock.
- Sits between the SPI-fed control/routing logic and a midi_out pin; one instance per MIDI output port.
- Generates MIDI traffic; the existing pass-through path only forwards it.

Parameters:
- CLK_DIV, 384: system clocks per bit (12 MHz / 31250); legal range 2..65535.
- FIFO_DEPTH, 4: byte FIFO entries; power of two, 2..16.
- CNT_W, 3: width of fifo_count, = log2(FIFO_DEPTH)+1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_data  input  8  byte to transmit.
- tx_valid  input  1  tx_data valid this cycle.
- tx_ready  output  1  FIFO can accept a byte this cycle.
- midi_out  output  1  serial line; idle high, registered.
- busy  output  1  high while the FIFO is non-empty or a frame is in progress.
- fifo_count  output  CNT_W  bytes currently buffered, excluding the byte being shifted.

Behaviour:
- Reset (sampled on a clk edge with reset=1):
  - FIFO empty, fifo_count=0, tx_ready=1, midi_out=1, busy=0, FSM in IDLE, baud counter=0.
  - Reset mid-frame aborts the frame immediately; midi_out returns high on the same edge.
- Handshake:
  - Push occurs when tx_valid & tx_ready at a clk edge.
  - tx_ready = (fifo_count != FIFO_DEPTH), combinational from registered count.
  - tx_data is ignored when tx_valid=0 or tx_ready=0; there is no overflow and no data loss.
- FIFO:
  - Circular buffer, pointers wrap modulo FIFO_DEPTH.
  - Push and pop on the same edge leave the count unchanged and are legal at any count.
  - Pop when empty never occurs.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop head into shift register, load baud counter with CLK_DIV-1, midi_out<=0, go to START. Otherwise midi_out<=1.
  - START: hold midi_out=0 for CLK_DIV cycles. At counter=0, reload, bit index<=0, midi_out<=shift[0], go to DATA.
  - DATA: each bit is held CLK_DIV cycles, LSB first. After bit 7 expires, midi_out<=1 and go to STOP.
  - STOP: hold midi_out=1 for CLK_DIV cycles. At expiry, if FIFO non-empty, pop, midi_out<=0 and go to START (no idle gap); else go to IDLE.
- Timing:
  - A byte pushed at edge k into an empty, idle block is popped at edge k+1. The start bit falling edge appears at k+1.
  - A frame is exactly 10*CLK_DIV cycles.
  - Back-to-back frames are continuous with no extra cycles between them.
- busy = (state != IDLE) | (fifo_count != 0).
- No running-status or message parsing; bytes are sent verbatim.

Decomposition:
- Package midi_pkg:
  - MIDI_BAUD=31250, default CLK_HZ=12000000, derived CLK_DIV default.
  - FSM state encoding constants (2-bit).
  - MIDI_STATUS_MASK=8'h80 for later blocks.
- One sub-module is natural: sync_fifo, parameterised by width and depth, with a push/pop/count interface. It can be reused by the planned MIDI receiver.
- The FSM and baud counter stay in midi_uart_tx.

Test Plan (CLK_DIV=4, FIFO_DEPTH=4 unless stated):
- Reset then idle 100 cycles -> midi_out=1, tx_ready=1, busy=0, fifo_count=0 throughout.
- Push 0x90 at edge k -> midi_out low from k+1 for 4 cycles, then bits 0,0,0,0,1,0,0,1 (4 cycles each), then high 4 cycles. busy falls at k+41.
- Push 0x90, 0x3C, 0x7F on consecutive cycles -> three contiguous 40-cycle frames with no gap. Decoded bytes in order; fifo_count peaks at 2.
- Hold tx_valid with 6 distinct bytes -> tx_ready drops when fifo_count=4. The remaining bytes are accepted as pops free slots; all 6 bytes are transmitted in order with none lost.
- Assert reset during bit 3 of a frame with 2 bytes queued -> midi_out=1 at the reset edge, FIFO cleared. No further frames until a new push.
- CLK_DIV=384, push 0xF8 -> each bit is 384 cycles and the frame totals 3840 cycles. Measured bit period is within 0 cycles of nominal.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared MIDI constants and types for the MIDI transmit/receive blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package midi_pkg;

    localparam int MIDI_BAUD       = 31250;
    localparam int CLK_HZ          = 12000000;
    // System clocks per serial bit at the default clock (384 at 12 MHz).
    localparam int CLK_DIV_DEFAULT = CLK_HZ / MIDI_BAUD;

    // Top bit set marks a MIDI status byte; kept here for the parsing blocks.
    localparam logic [7:0] MIDI_STATUS_MASK = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous circular-buffer FIFO with occupancy count.
// Latency: a pushed word is visible at pop_data_o the cycle after the push edge.
// Backpressure: caller must not push when full_o or pop when empty_o; push+pop on one edge keeps count.
// Ports: clk/reset (sync, active-high); push_i/push_data_i write side; pop_i/pop_data_o
//        read side (pop_data_o is the current head, combinational); count_o/full_o/empty_o status.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: count and pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);

endmodule

// File: rtl/midi_uart_tx.sv
// MIDI 8N1 serial transmitter fed from a byte FIFO over a valid/ready handshake.
// Latency: byte pushed into an empty idle block starts its start bit on the next edge; frame = 10*CLK_DIV clocks.
// Backpressure: tx_ready low while the FIFO is full; held bytes are accepted as frames drain, none dropped.
// Ports: clk/reset (sync, active-high); tx_data/tx_valid/tx_ready byte input handshake;
//        midi_out registered serial line (idle high); busy; fifo_count (bytes waiting, excluding the one shifting).
module midi_uart_tx
    import midi_pkg::*;
#(
    parameter int CLK_DIV    = CLK_DIV_DEFAULT,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             midi_out,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_count
);

    localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

    tx_state_e   state_q;
    logic [15:0] baud_cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic        midi_out_q;

    logic        fifo_push;
    logic        fifo_pop;
    logic [7:0]  fifo_head;
    logic        fifo_full;
    logic        fifo_empty;

    assign fifo_push = tx_valid & tx_ready;

    // A byte leaves the FIFO either from idle or exactly as a stop bit expires,
    // which is what makes back-to-back frames seamless.
    always_comb begin
        fifo_pop = 1'b0;
        if (!fifo_empty) begin
            if (state_q == ST_IDLE)
                fifo_pop = 1'b1;
            else if (state_q == ST_STOP && baud_cnt_q == '0)
                fifo_pop = 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i (tx_data),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Each bit is held for CLK_DIV edges: the counter is loaded with CLK_DIV-1
    // on the edge that drives the bit and the next bit is driven when it reads 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            midi_out_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        shift_q    <= fifo_head;
                        baud_cnt_q <= DIV_M1;
                        midi_out_q <= 1'b0;
                        state_q    <= ST_START;
                    end else begin
                        midi_out_q <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_cnt_q == '0) begin
                        baud_cnt_q <= DIV_M1;
                        bit_idx_q  <= '0;
                        midi_out_q <= shift_q[0];
                        state_q    <= ST_DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt_q == '0) begin
                        baud_cnt_q <= DIV_M1;
                        if (bit_idx_q == 3'd7) begin
                            midi_out_q <= 1'b1;
                            state_q    <= ST_STOP;
                        end else begin
                            // shift_q[0] is the bit on the line; [1] is next.
                            bit_idx_q  <= bit_idx_q + 3'd1;
                            shift_q    <= shift_q >> 1;
                            midi_out_q <= shift_q[1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (baud_cnt_q == '0) begin
                        if (fifo_pop) begin
                            shift_q    <= fifo_head;
                            baud_cnt_q <= DIV_M1;
                            midi_out_q <= 1'b0;
                            state_q    <= ST_START;
                        end else begin
                            state_q    <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    midi_out_q <= 1'b1;
                end
            endcase
        end
    end

    assign tx_ready = ~fifo_full;
    assign midi_out = midi_out_q;
    assign busy     = (state_q != ST_IDLE) || !fifo_empty;

endmodule
